// File: rtl/rc5_enc_sched.sv
// Round-robin front end sharing one rc5_enc_16bit core among NUM_REQ requesters.
// One job in flight at a time; a hung core is aborted after TIMEOUT wait cycles.
module rc5_enc_sched #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 255
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data,
    output logic [NUM_REQ-1:0]          req_ready,
    output logic                        rsp_valid,
    input  logic                        rsp_ready,
    output logic [DATA_W-1:0]           rsp_data,
    output logic [$clog2(NUM_REQ)-1:0]  rsp_id,
    output logic                        rsp_err,
    output logic                        core_start,
    output logic [DATA_W-1:0]           core_p,
    input  logic [DATA_W-1:0]           core_c,
    input  logic                        core_done,
    output logic                        busy
);

    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int TMR_W = $clog2(TIMEOUT + 1);
    localparam int unsigned NREQ_U = NUM_REQ;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_LAUNCH = 2'd1;
    localparam logic [1:0] S_WAIT   = 2'd2;
    localparam logic [1:0] S_RESP   = 2'd3;

    logic [1:0]       state;
    logic [ID_W-1:0]  rr_ptr;
    logic [TMR_W-1:0] timer;
    logic             first_wait;

    logic             grant_found;
    logic [ID_W-1:0]  grant_idx;
    int unsigned      cand;
    logic [ID_W-1:0]  cand_idx;

    // Search starts just past the last winner so the previous grantee has lowest priority.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = 0;
        cand_idx    = '0;
        for (int unsigned k = 1; k <= NREQ_U; k++) begin
            cand     = (32'(rr_ptr) + k) % NREQ_U;
            cand_idx = ID_W'(cand);
            if (!grant_found && req_valid[cand_idx]) begin
                grant_found = 1'b1;
                grant_idx   = cand_idx;
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (state == S_IDLE && grant_found) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    assign core_start = (state == S_LAUNCH);
    assign rsp_valid  = (state == S_RESP);
    assign busy       = (state != S_IDLE);

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= S_IDLE;
            rr_ptr     <= ID_W'(NUM_REQ - 1);
            timer      <= '0;
            first_wait <= 1'b0;
            core_p     <= '0;
            rsp_id     <= '0;
            rsp_data   <= '0;
            rsp_err    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (grant_found) begin
                        core_p <= req_data[int'(grant_idx)*DATA_W +: DATA_W];
                        rsp_id <= grant_idx;
                        rr_ptr <= grant_idx;
                        state  <= S_LAUNCH;
                    end
                end
                S_LAUNCH: begin
                    timer      <= '0;
                    first_wait <= 1'b1;
                    state      <= S_WAIT;
                end
                S_WAIT: begin
                    first_wait <= 1'b0;
                    // A done still high from the previous job is masked in the first wait cycle.
                    if (!first_wait && core_done) begin
                        rsp_data <= core_c;
                        rsp_err  <= 1'b0;
                        state    <= S_RESP;
                    end else if (timer == TMR_W'(TIMEOUT - 1)) begin
                        rsp_data <= '0;
                        rsp_err  <= 1'b1;
                        state    <= S_RESP;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rc5_enc_sched.sv
// Bench for rc5_enc_sched: directed scenarios plus randomized traffic, checked every
// cycle against a transaction-level model of the scheduler and a 12-cycle core model.
module tb_rc5_enc_sched;

    localparam int NR       = 4;
    localparam int DW       = 16;
    localparam int TO       = 255;
    localparam int DONE_LAT = 12;
    localparam logic [15:0] XK = 16'hA5A5;

    logic            clock = 1'b0;
    logic            reset = 1'b1;
    logic [NR-1:0]   req_valid = '0;
    logic [NR*DW-1:0] req_data = '0;
    logic [NR-1:0]   req_ready;
    logic            rsp_valid;
    logic            rsp_ready = 1'b1;
    logic [DW-1:0]   rsp_data;
    logic [1:0]      rsp_id;
    logic            rsp_err;
    logic            core_start;
    logic [DW-1:0]   core_p;
    logic [DW-1:0]   core_c = '0;
    logic            core_done = 1'b0;
    logic            busy;

    always #5 clock = ~clock;

    rc5_enc_sched #(.NUM_REQ(NR), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_id(rsp_id), .rsp_err(rsp_err),
        .core_start(core_start), .core_p(core_p), .core_c(core_c),
        .core_done(core_done), .busy(busy)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Core model: done 12 cycles after start, held until the next start
    logic        stale_mode = 1'b0;
    logic        hang_mode  = 1'b0;
    logic        stale_clr  = 1'b0;
    logic        armed      = 1'b0;
    int          cnt        = 0;
    logic [15:0] lat_p      = '0;

    always @(posedge clock) begin
        if (core_start) begin
            lat_p <= core_p;
            cnt   <= 1;
            armed <= !hang_mode;
            if (stale_mode) stale_clr <= 1'b1;
            else            core_done <= 1'b0;
        end else begin
            if (stale_clr) begin
                core_done <= 1'b0;
                stale_clr <= 1'b0;
            end
            if (armed) begin
                if (cnt == DONE_LAT - 1) begin
                    core_done <= 1'b1;
                    core_c    <= lat_p ^ XK;
                    armed     <= 1'b0;
                end else begin
                    cnt <= cnt + 1;
                end
            end
        end
    end

    // Scheduler model: a job exists from acceptance to response transfer
    logic          mv = 1'b0, job = 1'b0, decided = 1'b0;
    int            L = 0, rs_start = 0, acc_cyc = 0, rr = NR - 1, m_id = 0;
    logic [15:0]   m_p = '0, m_data = '0;
    logic          m_err = 1'b0;
    int            acc_seq = 0, acc_who = 0, nresp = 0;
    int            q_id[$], q_data[$], q_err[$], q_lat[$], q_rdy[$];
    int            wcnt[NR];
    int            g;
    logic          gf, rv;
    logic [NR-1:0] e;

    always @(negedge clock) begin
        cyc++;
        gf = 1'b0;
        g  = 0;
        for (int k = 1; k <= NR; k++) begin
            if (!gf && req_valid[(rr + k) % NR]) begin
                gf = 1'b1;
                g  = (rr + k) % NR;
            end
        end
        if (mv && !reset) begin
            e = '0;
            if (!job && gf) e[g] = 1'b1;
            rv = job && decided && (cyc >= rs_start);
            chk("req_ready",  32'(req_ready),  32'(e));
            chk("core_start", 32'(core_start), 32'(job && cyc == L));
            chk("busy",       32'(busy),       32'(job));
            chk("rsp_valid",  32'(rsp_valid),  32'(rv));
            chk("core_p",     32'(core_p),     32'(m_p));
            chk("rsp_id",     32'(rsp_id),     32'(m_id));
            chk("rsp_data",   32'(rsp_data),   32'(m_data));
            chk("rsp_err",    32'(rsp_err),    32'(m_err));
        end
        if (reset) begin
            mv = 1'b1; job = 1'b0; decided = 1'b0; rr = NR - 1;
            m_p = '0; m_data = '0; m_id = 0; m_err = 1'b0;
            for (int i = 0; i < NR; i++) wcnt[i] = 0;
        end else if (mv) begin
            for (int i = 0; i < NR; i++) if (!req_valid[i]) wcnt[i] = 0;
            if (!job) begin
                if (gf) begin
                    chk("fairness", 32'(wcnt[g] <= NR - 1), 32'd1);
                    for (int i = 0; i < NR; i++) begin
                        if (i == g) wcnt[i] = 0;
                        else if (req_valid[i]) wcnt[i]++;
                    end
                    q_rdy.push_back(int'(req_ready));
                    job = 1'b1; decided = 1'b0;
                    acc_cyc = cyc; L = cyc + 1;
                    m_p = req_data[g*DW +: DW];
                    m_id = g; rr = g;
                    acc_who = g; acc_seq++;
                end
            end else if (!decided) begin
                if (cyc >= L + 2 && core_done) begin
                    decided = 1'b1; m_data = m_p ^ XK; m_err = 1'b0; rs_start = cyc + 1;
                end else if (cyc == L + TO) begin
                    decided = 1'b1; m_data = '0; m_err = 1'b1; rs_start = cyc + 1;
                end
            end else if (cyc >= rs_start && rsp_ready) begin
                job = 1'b0;
                q_id.push_back(int'(rsp_id));
                q_data.push_back(int'(rsp_data));
                q_err.push_back(int'(rsp_err));
                q_lat.push_back(rs_start - acc_cyc);
                nresp++;
            end
        end
    end

    // Requester / consumer drivers, all owned by the main sequence
    logic [NR-1:0] pv = '0;
    logic [15:0]   pd[NR];
    logic          rand_on = 1'b0, rereq0 = 1'b0;
    logic [15:0]   rereq_data = '0;
    int            rdy_mode = 1;
    int            drv_seq = 0;

    task automatic apply();
        req_valid = pv;
        for (int i = 0; i < NR; i++) req_data[i*DW +: DW] = pd[i];
        rsp_ready = (rdy_mode == 2) ? ($urandom_range(3) != 0) : rdy_mode[0];
    endtask

    task automatic tick();
        @(posedge clock);
        #2;
        if (acc_seq != drv_seq) begin
            drv_seq = acc_seq;
            if (acc_who == 0 && rereq0) begin
                pd[0]  = rereq_data;
                rereq0 = 1'b0;
            end else begin
                pv[acc_who] = 1'b0;
            end
        end
        if (rand_on) begin
            for (int i = 0; i < NR; i++) begin
                if (!pv[i]) begin
                    if ($urandom_range(7) == 0) begin
                        pv[i] = 1'b1;
                        pd[i] = 16'($urandom);
                    end
                end else if ($urandom_range(63) == 0) begin
                    pv[i] = 1'b0;
                end
            end
        end
        apply();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        ticks(2);
        reset = 1'b0;
    endtask

    task automatic wait_resp(input int n, input int budget, input string name);
        int t = 0;
        while (nresp < n && t < budget) begin
            tick();
            t++;
        end
        chk(name, 32'(nresp >= n), 32'd1);
    endtask

    task automatic expect_rsp(input int idx, input int id, input int data, input int err, input int lat);
        if (idx >= q_id.size()) begin
            chk("rsp_present", 32'(q_id.size()), 32'(idx + 1));
            return;
        end
        chk("lit_id",   32'(q_id[idx]),   32'(id));
        chk("lit_data", 32'(q_data[idx]), 32'(data));
        chk("lit_err",  32'(q_err[idx]),  32'(err));
        chk("lit_lat",  32'(q_lat[idx]),  32'(lat));
    endtask

    task automatic req(input int i, input logic [15:0] d);
        pv[i] = 1'b1;
        pd[i] = d;
        apply();
    endtask

    initial begin
        #20000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, gbase, t;
        for (int i = 0; i < NR; i++) pd[i] = '0;
        ticks(3);
        reset = 1'b0;

        // Single request
        do_reset();
        base = nresp; gbase = q_rdy.size();
        req(0, 16'h1000);
        wait_resp(base + 1, 100, "t1_done");
        expect_rsp(base, 0, 16'hB5A5, 0, 14);
        if (q_rdy.size() > gbase) chk("t1_ready_mask", 32'(q_rdy[gbase]), 32'h1);
        else chk("t1_grant_seen", 32'(q_rdy.size()), 32'(gbase + 1));

        // Round-robin with requester 0 re-requesting immediately
        do_reset();
        base = nresp;
        rereq0 = 1'b1; rereq_data = 16'hBEEF;
        pv = '1; pd[0] = 16'hFFFF; pd[1] = 16'h00FF; pd[2] = 16'hFF00; pd[3] = 16'h1234;
        apply();
        wait_resp(base + 5, 200, "t2_done");
        expect_rsp(base + 0, 0, 16'h5A5A, 0, 14);
        expect_rsp(base + 1, 1, 16'hA55A, 0, 14);
        expect_rsp(base + 2, 2, 16'h5AA5, 0, 14);
        expect_rsp(base + 3, 3, 16'hB791, 0, 14);
        expect_rsp(base + 4, 0, 16'h1B4A, 0, 14);

        // Backpressure
        base = nresp;
        rdy_mode = 0;
        req(2, 16'h0F0F);
        t = 0;
        while (!rsp_valid && t < 100) begin tick(); t++; end
        chk("t3_valid_seen", 32'(rsp_valid), 32'd1);
        req(1, 16'h0001);
        ticks(20);
        chk("t3_no_transfer", 32'(nresp), 32'(base));
        chk("t3_still_busy", 32'(busy), 32'd1);
        rdy_mode = 1;
        apply();
        wait_resp(base + 2, 100, "t3_done");
        expect_rsp(base + 0, 2, 16'hAAAA, 0, 14);
        expect_rsp(base + 1, 1, 16'hA5A4, 0, 14);

        // Stale done at the next start
        stale_mode = 1'b1;
        base = nresp;
        req(3, 16'h0102);
        wait_resp(base + 1, 100, "t4a_done");
        req(3, 16'h0304);
        wait_resp(base + 2, 100, "t4b_done");
        expect_rsp(base + 0, 3, 16'hA4A7, 0, 14);
        expect_rsp(base + 1, 3, 16'hA6A1, 0, 14);
        stale_mode = 1'b0;

        // Timeout, then normal service
        hang_mode = 1'b1;
        base = nresp;
        req(1, 16'h5555);
        wait_resp(base + 1, 400, "t5_timeout");
        hang_mode = 1'b0;
        req(2, 16'h2222);
        wait_resp(base + 2, 100, "t5_after");
        expect_rsp(base + 0, 1, 16'h0000, 1, 257);
        expect_rsp(base + 1, 2, 16'h8787, 0, 14);

        // Reset during WAIT
        req(1, 16'h4444);
        t = 0;
        while (!core_start && t < 50) begin tick(); t++; end
        chk("t6_launch_seen", 32'(core_start), 32'd1);
        ticks(3);
        base = nresp;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("t6_rst_busy",       32'(busy),       32'd0);
        chk("t6_rst_rsp_valid",  32'(rsp_valid),  32'd0);
        chk("t6_rst_rsp_data",   32'(rsp_data),   32'd0);
        chk("t6_rst_rsp_id",     32'(rsp_id),     32'd0);
        chk("t6_rst_rsp_err",    32'(rsp_err),    32'd0);
        chk("t6_rst_core_start", 32'(core_start), 32'd0);
        chk("t6_rst_core_p",     32'(core_p),     32'd0);
        chk("t6_rst_req_ready",  32'(req_ready),  32'd0);
        ticks(30);
        chk("t6_no_abort_rsp", 32'(nresp), 32'(base));
        pv[0] = 1'b1; pd[0] = 16'h0A0A;
        pv[2] = 1'b1; pd[2] = 16'h2020;
        apply();
        wait_resp(base + 2, 100, "t6_done");
        expect_rsp(base + 0, 0, 16'hAFAF, 0, 14);
        expect_rsp(base + 1, 2, 16'h8585, 0, 14);

        // Randomized traffic with random backpressure
        rand_on = 1'b1;
        rdy_mode = 2;
        ticks(800);
        stale_mode = 1'b1;
        ticks(800);
        rand_on = 1'b0;
        rdy_mode = 1;
        apply();
        t = 0;
        while ((pv != '0 || job) && t < 3000) begin tick(); t++; end
        chk("drain", 32'(pv == '0 && !job), 32'd1);
        ticks(5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
